// File: rtl/cond_pkg.sv
// rtl/cond_pkg.sv - condition codes, flag indices and IT sequencer states for cond_logic_it
package cond_pkg;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_IT   = 1'b1
    } it_state_t;

endpackage

// File: rtl/cond_logic_it_if.sv
// rtl/cond_logic_it_if.sv - decode-side request and gated-control bundle for cond_logic_it
interface cond_logic_it_if #(
    parameter int FLAG_GROUPS = 2,
    parameter int IT_DEPTH    = 4,
    parameter int CNT_W       = 16
);
    localparam int LEN_W = $clog2(IT_DEPTH + 1);

    logic                   instr_valid;
    logic                   stall;
    logic                   flush;
    logic [3:0]             Cond;
    logic [3:0]             ALUFlags;
    logic [FLAG_GROUPS-1:0] FlagW;
    logic                   PCS;
    logic                   RegW;
    logic                   MemW;
    logic                   NoWrite;
    logic                   in_link;
    logic                   it_start;
    logic [3:0]             it_cond;
    logic [LEN_W-1:0]       it_len;
    logic [IT_DEPTH-1:0]    it_mask;
    logic                   PCSrc;
    logic                   RegWrite;
    logic                   MemWrite;
    logic                   link;
    logic [3:0]             Flags;
    logic                   it_active;
    logic                   it_err;
    logic [CNT_W-1:0]       squash_cnt;

    modport master (
        output instr_valid, stall, flush, Cond, ALUFlags, FlagW,
               PCS, RegW, MemW, NoWrite, in_link,
               it_start, it_cond, it_len, it_mask,
        input  PCSrc, RegWrite, MemWrite, link, Flags, it_active, it_err, squash_cnt
    );

    modport slave (
        input  instr_valid, stall, flush, Cond, ALUFlags, FlagW,
               PCS, RegW, MemW, NoWrite, in_link,
               it_start, it_cond, it_len, it_mask,
        output PCSrc, RegWrite, MemWrite, link, Flags, it_active, it_err, squash_cnt
    );

endinterface

// File: rtl/cond_check.sv
// rtl/cond_check.sv - combinational ARM condition evaluator with a forced-false input
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    input  logic       never,
    output logic       cond_ex
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        cond_ex = 1'b0;
        if (!never) begin
            case (cond)
                COND_EQ: cond_ex = z;
                COND_NE: cond_ex = ~z;
                COND_CS: cond_ex = c;
                COND_CC: cond_ex = ~c;
                COND_MI: cond_ex = n;
                COND_PL: cond_ex = ~n;
                COND_VS: cond_ex = v;
                COND_VC: cond_ex = ~v;
                COND_HI: cond_ex = c & ~z;
                COND_LS: cond_ex = ~c | z;
                COND_GE: cond_ex = (n == v);
                COND_LT: cond_ex = (n != v);
                COND_GT: cond_ex = ~z & (n == v);
                COND_LE: cond_ex = z | (n != v);
                // NV behaves as unconditional, like AL
                COND_AL, COND_NV: cond_ex = 1'b1;
                default: cond_ex = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/cond_logic_it.sv
// rtl/cond_logic_it.sv - grouped NZCV flags, condition gating and IT sequencer; COND_SQUASH_CNT_EN adds a squash counter
module cond_logic_it
    import cond_pkg::*;
#(
    parameter int FLAG_GROUPS = 2,
    parameter int IT_DEPTH    = 4,
    parameter int CNT_W       = 16
) (
    input  logic           CLK,
    input  logic           reset,
    cond_logic_it_if.slave bus
);

    localparam int LEN_W = $clog2(IT_DEPTH + 1);
    localparam int IDX_W = (IT_DEPTH > 1) ? $clog2(IT_DEPTH) : 1;

    it_state_t           state_q, state_d;
    logic [3:0]          it_cond_q, it_cond_d;
    logic [IT_DEPTH-1:0] it_mask_q, it_mask_d;
    logic [LEN_W-1:0]    it_len_q, it_len_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                it_err_q, it_err_d;
    logic [3:0]          flags_q;
    logic [3:0]          flag_we;

    logic       fire, it_instr, it_len_ok, last_slot, else_slot, never, cond_ex, act;
    logic [3:0] eff_cond;

    assign fire      = bus.instr_valid & ~bus.stall & ~bus.flush;
    // it_start only opens a block from IDLE; inside a block it is an ordinary covered instruction
    assign it_instr  = (state_q == ST_IDLE) & bus.it_start;
    assign it_len_ok = (bus.it_len != '0) && (bus.it_len <= LEN_W'(IT_DEPTH));
    assign last_slot = (LEN_W'(idx_q) == (it_len_q - LEN_W'(1)));
    assign else_slot = (state_q == ST_IT) & ~it_mask_q[idx_q];
    assign eff_cond  = (state_q == ST_IT) ? {it_cond_q[3:1], it_cond_q[0] ^ else_slot} : bus.Cond;
    assign never     = else_slot & (it_cond_q == COND_AL);

    cond_check u_cond_check (
        .cond    (eff_cond),
        .flags   (flags_q),
        .never   (never),
        .cond_ex (cond_ex)
    );

    assign act = fire & ~it_instr & cond_ex & ~reset;

    assign bus.PCSrc     = act & bus.PCS;
    assign bus.RegWrite  = act & bus.RegW & ~bus.NoWrite;
    assign bus.MemWrite  = act & bus.MemW;
    assign bus.link      = act & bus.in_link;
    assign bus.Flags     = flags_q;
    assign bus.it_active = (state_q == ST_IT) & ~reset;
    assign bus.it_err    = it_err_q;

    for (genvar b = 0; b < 4; b++) begin : g_flag_we
        assign flag_we[b] = bus.FlagW[b * FLAG_GROUPS / 4];
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            flags_q <= 4'b0000;
        end else if (fire & ~it_instr & cond_ex) begin
            flags_q <= (flags_q & ~flag_we) | (bus.ALUFlags & flag_we);
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            it_cond_q <= 4'b0000;
            it_mask_q <= '0;
            it_len_q  <= '0;
            idx_q     <= '0;
            it_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            it_cond_q <= it_cond_d;
            it_mask_q <= it_mask_d;
            it_len_q  <= it_len_d;
            idx_q     <= idx_d;
            it_err_q  <= it_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        it_cond_d = it_cond_q;
        it_mask_d = it_mask_q;
        it_len_d  = it_len_q;
        idx_d     = idx_q;
        it_err_d  = it_err_q;
        if (bus.flush) begin
            state_d = ST_IDLE;
            idx_d   = '0;
        end else if (fire) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.it_start) begin
                        if (it_len_ok) begin
                            it_cond_d = bus.it_cond;
                            it_mask_d = bus.it_mask;
                            it_len_d  = bus.it_len;
                            idx_d     = '0;
                            state_d   = ST_IT;
                        end else begin
                            it_err_d = 1'b1;
                        end
                    end
                end
                ST_IT: begin
                    if (bus.it_start) begin
                        it_err_d = 1'b1;
                    end
                    if (last_slot) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

`ifdef COND_SQUASH_CNT_EN
    logic [CNT_W-1:0] squash_q;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            squash_q <= '0;
        end else if (fire & ~it_instr & ~cond_ex & ~(&squash_q)) begin
            squash_q <= squash_q + 1'b1;
        end
    end

    assign bus.squash_cnt = squash_q;
`else
    assign bus.squash_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_cond_logic_it.sv
// tb/tb_cond_logic_it.sv - scoreboard bench for cond_logic_it with directed vectors
module tb_cond_logic_it;
    import cond_pkg::*;

    localparam int FG  = 2;
    localparam int ITD = 4;
    localparam int CW  = 4;

    logic CLK   = 1'b0;
    logic reset = 1'b1;
    always #5 CLK = ~CLK;

    cond_logic_it_if #(.FLAG_GROUPS(FG), .IT_DEPTH(ITD), .CNT_W(CW)) bus ();

    cond_logic_it #(.FLAG_GROUPS(FG), .IT_DEPTH(ITD), .CNT_W(CW)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic       v, st, fl, nw, its;
        logic [3:0] cond, alu, ctl, itc, itm;
        logic [1:0] fw;
        logic [2:0] itl;
    } stim_t;

    typedef struct {
        string       name;
        logic [3:0]  ctl, flags;
        logic        ita, err, chk_sq;
        logic [CW-1:0] sq;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    function automatic stim_t ins(logic [3:0] c, logic [3:0] ctl, logic [1:0] fw = 2'b00,
                                  logic [3:0] alu = 4'b0000);
        stim_t s;
        s = idle();
        s.v = 1'b1; s.cond = c; s.ctl = ctl; s.fw = fw; s.alu = alu;
        return s;
    endfunction

    function automatic stim_t itins(logic [3:0] c, logic [2:0] len, logic [3:0] mask);
        stim_t s;
        s = idle();
        s.v = 1'b1; s.its = 1'b1; s.itc = c; s.itl = len; s.itm = mask;
        return s;
    endfunction

    function automatic exp_t ex(string n, logic [3:0] ctl, logic [3:0] fl, logic ita, logic err);
        exp_t e;
        e.name = n; e.ctl = ctl; e.flags = fl; e.ita = ita; e.err = err;
        e.chk_sq = 1'b0; e.sq = '0;
        return e;
    endfunction

    function automatic exp_t exs(string n, logic [3:0] ctl, logic [3:0] fl, logic ita, logic err,
                                 logic [CW-1:0] sq);
        exp_t e;
        e = ex(n, ctl, fl, ita, err);
        e.chk_sq = 1'b1; e.sq = sq;
        return e;
    endfunction

    task automatic apply(input stim_t s);
        bus.instr_valid = s.v;   bus.stall    = s.st;  bus.flush   = s.fl;
        bus.Cond        = s.cond; bus.ALUFlags = s.alu; bus.FlagW   = s.fw;
        bus.PCS         = s.ctl[3]; bus.RegW  = s.ctl[2]; bus.MemW = s.ctl[1];
        bus.in_link     = s.ctl[0]; bus.NoWrite = s.nw;
        bus.it_start    = s.its; bus.it_cond  = s.itc; bus.it_len  = s.itl; bus.it_mask = s.itm;
    endtask

    task automatic step(input stim_t s, input exp_t e);
        @(posedge CLK);
        #1;
        apply(s);
        sb.push_back(e);
    endtask

    task automatic step_rst_mid(input stim_t s, input exp_t e);
        @(posedge CLK);
        #1;
        apply(s);
        #1;
        reset = 1'b1;
        sb.push_back(e);
    endtask

    task automatic release_rst();
        @(posedge CLK);
        #1;
        reset = 1'b0;
        apply(idle());
        sb.push_back(exs("rst_rel", 4'h0, 4'h0, 1'b0, 1'b0, '0));
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1;
        reset = 1'b1;
        apply(idle());
        sb.push_back(exs("rst", 4'h0, 4'h0, 1'b0, 1'b0, '0));
        release_rst();
    endtask

    task automatic chk(input string n, input string f, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s actual=%0h required=%0h", n, f, act, req);
        end
    endtask

    always @(negedge CLK) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk(mon_e.name, "ctl", {28'd0, bus.PCSrc, bus.RegWrite, bus.MemWrite, bus.link}, {28'd0, mon_e.ctl});
            chk(mon_e.name, "flags", {28'd0, bus.Flags}, {28'd0, mon_e.flags});
            chk(mon_e.name, "it_active", {31'd0, bus.it_active}, {31'd0, mon_e.ita});
            chk(mon_e.name, "it_err", {31'd0, bus.it_err}, {31'd0, mon_e.err});
            if (mon_e.chk_sq)
                chk(mon_e.name, "squash_cnt", {{(32-CW){1'b0}}, bus.squash_cnt}, {{(32-CW){1'b0}}, mon_e.sq});
        end
    end

    stim_t s;
    int    sq_model;

    initial begin
        apply(idle());
        do_reset();

        // flag groups: low group then high group
        step(ins(COND_AL, 4'b0000, 2'b01, 4'b0100), ex("fg_lo", 4'h0, 4'b0000, 0, 0));
        step(ins(COND_AL, 4'b0000, 2'b10, 4'b0100), ex("fg_hi", 4'h0, 4'b0000, 0, 0));
        step(ins(COND_EQ, 4'b0100), ex("eq_z", 4'b0100, 4'b0100, 0, 0));

        // failing condition and stall
        step(ins(COND_NE, 4'b1110), ex("ne_fail", 4'h0, 4'b0100, 0, 0));
        s = ins(COND_EQ, 4'b1110, 2'b11, 4'b1011); s.st = 1'b1;
        step(s, ex("stall", 4'h0, 4'b0100, 0, 0));
        step(ins(COND_EQ, 4'b1111), ex("post_stall", 4'b1111, 4'b0100, 0, 0));
        s = ins(COND_EQ, 4'b0100); s.nw = 1'b1;
        step(s, ex("nowrite", 4'h0, 4'b0100, 0, 0));

        // IT EQ, len 3, then/else/then
        s = itins(COND_EQ, 3'd3, 4'b0101); s.ctl = 4'b0100;
        step(s, ex("it_instr", 4'h0, 4'b0100, 0, 0));
        step(ins(COND_NE, 4'b0100), ex("it_s0", 4'b0100, 4'b0100, 1, 0));
        s = ins(COND_AL, 4'b0100); s.st = 1'b1;
        step(s, ex("it_stall", 4'h0, 4'b0100, 1, 0));
        step(ins(COND_AL, 4'b0100), ex("it_s1", 4'h0, 4'b0100, 1, 0));
        step(ins(COND_NE, 4'b0100), ex("it_s2", 4'b0100, 4'b0100, 1, 0));
        step(ins(COND_AL, 4'b0100), ex("it_done", 4'b0100, 4'b0100, 0, 0));

        // flush mid-block
        step(itins(COND_EQ, 3'd3, 4'b0111), ex("fl_it", 4'h0, 4'b0100, 0, 0));
        step(ins(COND_NE, 4'b0100), ex("fl_s0", 4'b0100, 4'b0100, 1, 0));
        s = ins(COND_AL, 4'b0100); s.fl = 1'b1;
        step(s, ex("flush", 4'h0, 4'b0100, 1, 0));
        step(ins(COND_AL, 4'b0100), ex("post_fl", 4'b0100, 4'b0100, 0, 0));

        // asynchronous reset inside a block
        step(itins(COND_EQ, 3'd2, 4'b0011), ex("ar_it", 4'h0, 4'b0100, 0, 0));
        step(ins(COND_NE, 4'b0100), ex("ar_s0", 4'b0100, 4'b0100, 1, 0));
        step_rst_mid(ins(COND_EQ, 4'b0100), exs("async_rst", 4'h0, 4'h0, 0, 0, '0));
        release_rst();

        // illegal length 0
        step(itins(COND_EQ, 3'd0, 4'b0000), ex("len0", 4'h0, 4'h0, 0, 0));
        step(ins(COND_AL, 4'b0100), ex("len0_idle", 4'b0100, 4'h0, 0, 1));

        // nested it_start and else slot of AL
        do_reset();
        step(itins(COND_AL, 3'd2, 4'b0001), ex("al_it", 4'h0, 4'h0, 0, 0));
        s = itins(COND_EQ, 3'd3, 4'b0000); s.ctl = 4'b0100;
        step(s, ex("nested", 4'b0100, 4'h0, 1, 0));
        step(ins(COND_AL, 4'b0100), ex("al_else", 4'h0, 4'h0, 1, 1));
        step(ins(COND_AL, 4'b0100), ex("al_done", 4'b0100, 4'h0, 0, 1));

        // illegal length above IT_DEPTH
        do_reset();
        step(itins(COND_EQ, 3'd5, 4'b1111), ex("len5", 4'h0, 4'h0, 0, 0));
        step(ins(COND_AL, 4'b0100), ex("len5_idle", 4'b0100, 4'h0, 0, 1));

        // condition table spot checks, N=1 V=1
        do_reset();
        step(ins(COND_AL, 4'b0000, 2'b11, 4'b1001), ex("set_nv", 4'h0, 4'h0, 0, 0));
        step(ins(COND_GE, 4'b0100), ex("ge", 4'b0100, 4'b1001, 0, 0));
        step(ins(COND_LT, 4'b0100), ex("lt", 4'h0, 4'b1001, 0, 0));
        step(ins(COND_HI, 4'b0100), ex("hi", 4'h0, 4'b1001, 0, 0));
        step(ins(COND_LE, 4'b0100), ex("le", 4'h0, 4'b1001, 0, 0));
        step(ins(COND_NV, 4'b0100), ex("nv", 4'b0100, 4'b1001, 0, 0));
        step(ins(COND_MI, 4'b0001), ex("mi_link", 4'b0001, 4'b1001, 0, 0));

        // squash counter: 17 failing EQ instructions with Z=0, one excluded IT instruction
        do_reset();
        step(itins(COND_EQ, 3'd0, 4'b0000), exs("sq_it", 4'h0, 4'h0, 0, 0, '0));
        for (int k = 0; k < 17; k++) begin
`ifdef COND_SQUASH_CNT_EN
            sq_model = (k > 15) ? 15 : k;
`else
            sq_model = 0;
`endif
            step(ins(COND_EQ, 4'b0100), exs("sq", 4'h0, 4'h0, 0, 1, CW'(sq_model)));
        end
`ifdef COND_SQUASH_CNT_EN
        sq_model = 15;
`else
        sq_model = 0;
`endif
        step(idle(), exs("sq_final", 4'h0, 4'h0, 0, 1, CW'(sq_model)));

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge CLK);
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain actual=%0d required=0", sb.size());
        end
        @(posedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
